// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin pick of one completed result per cycle into a
// registered register-file write port. Define WB_FWD_EN to add decode bypass ports.
module wb_arbiter #(
    parameter int unsigned N_SRC = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    output logic [N_SRC-1:0]     src_ready,
    input  logic [5*N_SRC-1:0]   src_rd,
    input  logic [N_SRC-1:0]     src_isf,
    input  logic [32*N_SRC-1:0]  src_data,
    output logic                 reg_write,
    output logic [4:0]           write_reg,
    output logic [31:0]          write_data,
    output logic                 write_f
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]           fwd_rs1,
    input  logic [4:0]           fwd_rs2,
    input  logic                 fwd_rs1_f,
    input  logic                 fwd_rs2_f,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [31:0]          fwd_data1,
    output logic [31:0]          fwd_data2
`endif
);

    localparam int unsigned PW = $clog2(N_SRC);

    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  gidx;
    logic [PW-1:0]  scan_idx;
    logic [PW:0]    scan_sum;
    logic           found;
    logic           xfer;
    logic [4:0]     rd_arr   [N_SRC];
    logic [31:0]    data_arr [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign rd_arr[g]   = src_rd[5*g +: 5];
        assign data_arr[g] = src_data[32*g +: 32];
    end

    // First valid source at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(N_SRC)) begin
                scan_sum = scan_sum - (PW+1)'(N_SRC);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!found && src_valid[scan_idx]) begin
                found = 1'b1;
                gidx  = scan_idx;
            end
        end
    end

    assign xfer = found & ~rst;

    always_comb begin
        src_ready = '0;
        if (xfer) begin
            src_ready[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            write_f    <= 1'b0;
        end else if (xfer) begin
            rr_ptr     <= (gidx == PW'(N_SRC-1)) ? '0 : gidx + 1'b1;
            write_reg  <= rd_arr[gidx];
            write_data <= data_arr[gidx];
            write_f    <= src_isf[gidx];
            // Integer x0 is consumed from the source but never written.
            reg_write  <= src_isf[gidx] | (rd_arr[gidx] != 5'd0);
        end else begin
            reg_write  <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit1  = reg_write & (write_reg == fwd_rs1) & (write_f == fwd_rs1_f);
    assign fwd_hit2  = reg_write & (write_reg == fwd_rs2) & (write_f == fwd_rs2_f);
    assign fwd_data1 = fwd_hit1 ? write_data : '0;
    assign fwd_data2 = fwd_hit2 ? write_data : '0;
`endif

endmodule
